// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns a command/response handshake into
// AXI-lite reads and writes, with a per-transaction timeout.
module axi_lite_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

    state_t                state, state_nx;
    logic                  cmd_ready_r, cmd_ready_nx;
    logic                  awvalid_r, awvalid_nx, wvalid_r, wvalid_nx, arvalid_r, arvalid_nx;
    logic                  bready_r, bready_nx, rready_r, rready_nx;
    logic                  aw_done, aw_done_nx, w_done, w_done_nx;
    logic [ADDR_WIDTH-1:0] addr_r, addr_nx;
    logic [31:0]           wdata_r, wdata_nx;
    logic [3:0]            wstrb_r, wstrb_nx;
    logic                  write_r, write_nx;
    logic                  rsp_valid_r, rsp_valid_nx, rsp_write_r, rsp_write_nx;
    logic [31:0]           rsp_rdata_r, rsp_rdata_nx;
    logic [1:0]            rsp_resp_r, rsp_resp_nx;
    logic                  rsp_timeout_r, rsp_timeout_nx;
    logic [CNT_W-1:0]      tcount, tcount_nx;
    logic                  in_txn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cmd_ready_r   <= 1'b0;
            awvalid_r     <= 1'b0;
            wvalid_r      <= 1'b0;
            arvalid_r     <= 1'b0;
            bready_r      <= 1'b0;
            rready_r      <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            addr_r        <= '0;
            wdata_r       <= '0;
            wstrb_r       <= '0;
            write_r       <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_write_r   <= 1'b0;
            rsp_rdata_r   <= '0;
            rsp_resp_r    <= '0;
            rsp_timeout_r <= 1'b0;
            tcount        <= '0;
        end else begin
            state         <= state_nx;
            cmd_ready_r   <= cmd_ready_nx;
            awvalid_r     <= awvalid_nx;
            wvalid_r      <= wvalid_nx;
            arvalid_r     <= arvalid_nx;
            bready_r      <= bready_nx;
            rready_r      <= rready_nx;
            aw_done       <= aw_done_nx;
            w_done        <= w_done_nx;
            addr_r        <= addr_nx;
            wdata_r       <= wdata_nx;
            wstrb_r       <= wstrb_nx;
            write_r       <= write_nx;
            rsp_valid_r   <= rsp_valid_nx;
            rsp_write_r   <= rsp_write_nx;
            rsp_rdata_r   <= rsp_rdata_nx;
            rsp_resp_r    <= rsp_resp_nx;
            rsp_timeout_r <= rsp_timeout_nx;
            tcount        <= tcount_nx;
        end
    end

    assign in_txn = (state == WR_REQ) || (state == WR_RESP) || (state == RD_REQ) || (state == RD_RESP);

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        state_nx       = state;
        awvalid_nx     = awvalid_r;
        wvalid_nx      = wvalid_r;
        arvalid_nx     = arvalid_r;
        bready_nx      = bready_r;
        rready_nx      = rready_r;
        aw_done_nx     = aw_done;
        w_done_nx      = w_done;
        addr_nx        = addr_r;
        wdata_nx       = wdata_r;
        wstrb_nx       = wstrb_r;
        write_nx       = write_r;
        rsp_valid_nx   = 1'b0;
        rsp_write_nx   = rsp_write_r;
        rsp_rdata_nx   = rsp_rdata_r;
        rsp_resp_nx    = rsp_resp_r;
        rsp_timeout_nx = rsp_timeout_r;
        tcount_nx      = in_txn ? tcount + CNT_W'(1) : tcount;

        case (state)
            IDLE: begin
                tcount_nx = '0;
                if (cmd_valid && cmd_ready_r) begin
                    addr_nx    = cmd_addr;
                    wdata_nx   = cmd_wdata;
                    wstrb_nx   = cmd_wstrb;
                    write_nx   = cmd_write;
                    aw_done_nx = 1'b0;
                    w_done_nx  = 1'b0;
                    if (cmd_write) begin
                        state_nx   = WR_REQ;
                        awvalid_nx = 1'b1;
                        wvalid_nx  = 1'b1;
                    end else begin
                        state_nx   = RD_REQ;
                        arvalid_nx = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently; move on once both are recorded
                if (awvalid_r && m_axi_awready) begin
                    awvalid_nx = 1'b0;
                    aw_done_nx = 1'b1;
                end
                if (wvalid_r && m_axi_wready) begin
                    wvalid_nx = 1'b0;
                    w_done_nx = 1'b1;
                end
                if (aw_done && w_done) begin
                    state_nx  = WR_RESP;
                    bready_nx = 1'b1;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid && bready_r) begin
                    bready_nx      = 1'b0;
                    rsp_valid_nx   = 1'b1;
                    rsp_write_nx   = 1'b1;
                    rsp_rdata_nx   = '0;
                    rsp_resp_nx    = m_axi_bresp;
                    rsp_timeout_nx = 1'b0;
                    state_nx       = DONE;
                end
            end
            RD_REQ: begin
                if (arvalid_r && m_axi_arready) begin
                    arvalid_nx = 1'b0;
                    rready_nx  = 1'b1;
                    state_nx   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_axi_rvalid && rready_r) begin
                    rready_nx      = 1'b0;
                    rsp_valid_nx   = 1'b1;
                    rsp_write_nx   = 1'b0;
                    rsp_rdata_nx   = m_axi_rdata;
                    rsp_resp_nx    = m_axi_rresp;
                    rsp_timeout_nx = 1'b0;
                    state_nx       = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Abort on timeout unless the transaction completed on this same edge
        if ((TIMEOUT_CYCLES != 0) && in_txn && (state_nx != DONE) &&
            (32'(tcount_nx) == TIMEOUT_CYCLES)) begin
            awvalid_nx     = 1'b0;
            wvalid_nx      = 1'b0;
            arvalid_nx     = 1'b0;
            bready_nx      = 1'b0;
            rready_nx      = 1'b0;
            rsp_valid_nx   = 1'b1;
            rsp_write_nx   = write_r;
            rsp_rdata_nx   = '0;
            rsp_resp_nx    = 2'b10;
            rsp_timeout_nx = 1'b1;
            state_nx       = DONE;
        end

        cmd_ready_nx = (state_nx == IDLE);
    end

    assign cmd_ready     = cmd_ready_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_write     = rsp_write_r;
    assign rsp_rdata     = rsp_rdata_r;
    assign rsp_resp      = rsp_resp_r;
    assign rsp_timeout   = rsp_timeout_r;
    assign m_axi_awaddr  = addr_r;
    assign m_axi_araddr  = addr_r;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_awvalid = awvalid_r;
    assign m_axi_wdata   = wdata_r;
    assign m_axi_wstrb   = wstrb_r;
    assign m_axi_wvalid  = wvalid_r;
    assign m_axi_bready  = bready_r;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = rready_r;

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: reactive AXI-lite slave model,
// handshake monitor and an expected-response queue.
module tb_axi_lite_master;

    localparam int unsigned AW  = 32;
    localparam int unsigned TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid, rsp_write, rsp_timeout;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;

    axi_lite_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0, n_fail = 0;
    int          cyc = 0;
    int          aw_lat = 0, w_lat = 0, ar_lat = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = '0;
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int          aw_vcyc = 0, w_vcyc = 0, ar_vcyc = 0, aw_unstable = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0, aw_prev_addr = '0;
    logic [3:0]  last_wstrb = '0;
    logic        aw_prev_pend = 1'b0;

    // Handshake monitor: counts VALID cycles and completed handshakes per channel
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            aw_vcyc = 0; w_vcyc = 0; ar_vcyc = 0; aw_unstable = 0; aw_prev_pend = 1'b0;
        end else begin
            if (awvalid) aw_vcyc++;
            if (wvalid) w_vcyc++;
            if (arvalid) ar_vcyc++;
            if (aw_prev_pend && awvalid && (awaddr !== aw_prev_addr)) aw_unstable++;
            aw_prev_pend = awvalid && !awready;
            aw_prev_addr = awaddr;
            if (awvalid && awready) begin aw_hs++; last_awaddr = awaddr; end
            if (wvalid && wready) begin w_hs++; last_wdata = wdata; last_wstrb = wstrb; end
            if (bvalid && bready) b_hs++;
            if (arvalid && arready) begin ar_hs++; last_araddr = araddr; end
            if (rvalid && rready) r_hs++;
        end
    end

    // Slave model: programmable READY latency, B/R issued once the requests are taken
    initial begin
        int aw_cnt, w_cnt, ar_cnt;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            end else begin
                if (awvalid) begin awready = (aw_cnt == aw_lat); aw_cnt++; end
                else begin awready = 0; aw_cnt = 0; end
                if (wvalid) begin wready = (w_cnt == w_lat); w_cnt++; end
                else begin wready = 0; w_cnt = 0; end
                if (arvalid) begin arready = (ar_cnt == ar_lat); ar_cnt++; end
                else begin arready = 0; ar_cnt = 0; end
                bvalid = (((aw_hs < w_hs) ? aw_hs : w_hs) > b_hs);
                bresp  = cfg_bresp;
                rvalid = (ar_hs > r_hs);
                rdata  = rvalid ? cfg_rdata : 32'h0;
                rresp  = cfg_rresp;
            end
        end
    end

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int acc, output bit ok);
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        ok = 0; acc = 0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin ok = 1; acc = cyc; break; end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit found, output int at);
        found = 0; at = 0;
        for (int i = 0; i < 64; i++) begin
            if (rsp_valid) begin found = 1; at = cyc; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
        n_checks++; if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin n_fail++; $display("FAIL reset_axi_handshake: got %b expected 00000", {awvalid, wvalid, arvalid, bready, rready}); end
        n_checks++; if ({rsp_valid, rsp_timeout, rsp_resp, rsp_rdata, awaddr} !== '0) begin n_fail++; $display("FAIL reset_rsp_addr: got nonzero rsp/addr state expected 0"); end
        rst = 1'b0;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL release_before_edge: got %b expected 0", cmd_ready); end
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL release_cmd_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_write_basic();
        int acc, at, s_aw, s_w, s_b; bit ok, found; exp_t e;
        aw_lat = 0; w_lat = 0; cfg_bresp = 2'b00;
        s_aw = aw_vcyc; s_w = w_vcyc; s_b = b_hs;
        send(1'b1, 32'h8, 32'h5, 4'hF, acc, ok);
        if (ok) sb.push_back('{1'b1, 32'h0, 2'b00, 1'b0});
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wr_accept: got no accept expected accept"); end
        wait_rsp(found, at);
        n_checks++; if (!found) begin n_fail++; $display("FAIL wr_rsp: got no rsp_valid expected rsp_valid"); end
        if (found && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++; if (rsp_write !== e.write) begin n_fail++; $display("FAIL wr_rsp_write: got %b expected %b", rsp_write, e.write); end
            n_checks++; if (rsp_resp !== e.resp) begin n_fail++; $display("FAIL wr_rsp_resp: got %b expected %b", rsp_resp, e.resp); end
            n_checks++; if (rsp_timeout !== e.tmo) begin n_fail++; $display("FAIL wr_rsp_timeout: got %b expected %b", rsp_timeout, e.tmo); end
            n_checks++; if ((at - acc) != 4) begin n_fail++; $display("FAIL wr_latency: got %0d expected 4", at - acc); end
        end
        n_checks++; if ((aw_vcyc - s_aw) != 1) begin n_fail++; $display("FAIL wr_awvalid_cycles: got %0d expected 1", aw_vcyc - s_aw); end
        n_checks++; if ((w_vcyc - s_w) != 1) begin n_fail++; $display("FAIL wr_wvalid_cycles: got %0d expected 1", w_vcyc - s_w); end
        n_checks++; if ((b_hs - s_b) != 1) begin n_fail++; $display("FAIL wr_b_count: got %0d expected 1", b_hs - s_b); end
        n_checks++; if ({last_awaddr, last_wdata, last_wstrb, awprot} !== {32'h8, 32'h5, 4'hF, 3'b000}) begin n_fail++; $display("FAIL wr_payload: got %h/%h/%h/%b expected 8/5/f/000", last_awaddr, last_wdata, last_wstrb, awprot); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_pulse: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_read_basic();
        int acc, at, s_ar; bit ok, found; exp_t e;
        ar_lat = 0; cfg_rresp = 2'b00; cfg_rdata = 32'h0000000A;
        s_ar = ar_vcyc;
        send(1'b0, 32'hC, 32'h0, 4'h0, acc, ok);
        if (ok) sb.push_back('{1'b0, 32'h0000000A, 2'b00, 1'b0});
        wait_rsp(found, at);
        n_checks++; if (!(ok && found)) begin n_fail++; $display("FAIL rd_rsp: got accept=%0b rsp=%0b expected 1/1", ok, found); end
        if (found && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++; if ({rsp_write, rsp_rdata, rsp_resp, rsp_timeout} !== e) begin n_fail++; $display("FAIL rd_rsp_fields: got %b/%h/%b/%b expected %b/%h/%b/%b", rsp_write, rsp_rdata, rsp_resp, rsp_timeout, e.write, e.rdata, e.resp, e.tmo); end
            n_checks++; if ((at - acc) != 3) begin n_fail++; $display("FAIL rd_latency: got %0d expected 3", at - acc); end
        end
        n_checks++; if ((ar_vcyc - s_ar) != 1) begin n_fail++; $display("FAIL rd_arvalid_cycles: got %0d expected 1", ar_vcyc - s_ar); end
        n_checks++; if ({last_araddr, arprot} !== {32'hC, 3'b000}) begin n_fail++; $display("FAIL rd_araddr: got %h/%b expected c/000", last_araddr, arprot); end
    endtask

    task automatic test_write_wready_first();
        int acc, at, s_aw, s_w, s_b, s_un; bit ok, found; exp_t e;
        aw_lat = 3; w_lat = 0; cfg_bresp = 2'b00;
        s_aw = aw_vcyc; s_w = w_vcyc; s_b = b_hs; s_un = aw_unstable;
        send(1'b1, 32'h20, 32'hDEADBEEF, 4'h3, acc, ok);
        if (ok) sb.push_back('{1'b1, 32'h0, 2'b00, 1'b0});
        wait_rsp(found, at);
        n_checks++; if (!(ok && found)) begin n_fail++; $display("FAIL wfirst_rsp: got accept=%0b rsp=%0b expected 1/1", ok, found); end
        if (found && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++; if ({rsp_write, rsp_resp, rsp_timeout} !== {e.write, e.resp, e.tmo}) begin n_fail++; $display("FAIL wfirst_rsp_fields: got %b/%b/%b expected %b/%b/%b", rsp_write, rsp_resp, rsp_timeout, e.write, e.resp, e.tmo); end
        end
        n_checks++; if ((aw_vcyc - s_aw) != 4) begin n_fail++; $display("FAIL wfirst_awvalid_cycles: got %0d expected 4", aw_vcyc - s_aw); end
        n_checks++; if ((w_vcyc - s_w) != 1) begin n_fail++; $display("FAIL wfirst_wvalid_cycles: got %0d expected 1", w_vcyc - s_w); end
        n_checks++; if ((aw_unstable - s_un) != 0) begin n_fail++; $display("FAIL wfirst_awaddr_stable: got %0d changes expected 0", aw_unstable - s_un); end
        n_checks++; if ((b_hs - s_b) != 1) begin n_fail++; $display("FAIL wfirst_b_count: got %0d expected 1", b_hs - s_b); end
        n_checks++; if (last_awaddr !== 32'h20) begin n_fail++; $display("FAIL wfirst_awaddr: got %h expected 20", last_awaddr); end
        aw_lat = 0;
    endtask

    task automatic test_back_to_back();
        int acc, at, acc2, at2; bit ok, found, ok2, found2; exp_t e;
        ar_lat = 0; cfg_rresp = 2'b10; cfg_rdata = 32'h00001234;
        send(1'b0, 32'hD, 32'h0, 4'h0, acc, ok);
        if (ok) sb.push_back('{1'b0, 32'h00001234, 2'b10, 1'b0});
        wait_rsp(found, at);
        n_checks++; if (!(ok && found)) begin n_fail++; $display("FAIL slverr_rsp: got accept=%0b rsp=%0b expected 1/1", ok, found); end
        if (found && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++; if ({rsp_write, rsp_rdata, rsp_resp, rsp_timeout} !== e) begin n_fail++; $display("FAIL slverr_fields: got %b/%h/%b/%b expected %b/%h/%b/%b", rsp_write, rsp_rdata, rsp_resp, rsp_timeout, e.write, e.rdata, e.resp, e.tmo); end
        end
        cfg_rresp = 2'b00; cfg_rdata = 32'h55AA0F0F;
        send(1'b0, 32'h10, 32'h0, 4'h0, acc2, ok2);
        if (ok2) sb.push_back('{1'b0, 32'h55AA0F0F, 2'b00, 1'b0});
        n_checks++; if (!ok2 || (acc2 != at + 1)) begin n_fail++; $display("FAIL b2b_accept_cycle: got %0d expected %0d", acc2, at + 1); end
        wait_rsp(found2, at2);
        n_checks++; if (!found2) begin n_fail++; $display("FAIL b2b_rsp: got no rsp_valid expected rsp_valid"); end
        if (found2 && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++; if ({rsp_write, rsp_rdata, rsp_resp, rsp_timeout} !== e) begin n_fail++; $display("FAIL b2b_fields: got %b/%h/%b/%b expected %b/%h/%b/%b", rsp_write, rsp_rdata, rsp_resp, rsp_timeout, e.write, e.rdata, e.resp, e.tmo); end
        end
    endtask

    task automatic test_timeout();
        int acc, at, s_ar; bit ok, found; exp_t e;
        ar_lat = 1000; cfg_rresp = 2'b00; cfg_rdata = 32'hFFFFFFFF;
        s_ar = ar_vcyc;
        send(1'b0, 32'h40, 32'h0, 4'h0, acc, ok);
        if (ok) sb.push_back('{1'b0, 32'h0, 2'b10, 1'b1});
        wait_rsp(found, at);
        n_checks++; if (!(ok && found)) begin n_fail++; $display("FAIL tmo_rsp: got accept=%0b rsp=%0b expected 1/1", ok, found); end
        if (found && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++; if ({rsp_write, rsp_rdata, rsp_resp, rsp_timeout} !== e) begin n_fail++; $display("FAIL tmo_fields: got %b/%h/%b/%b expected %b/%h/%b/%b", rsp_write, rsp_rdata, rsp_resp, rsp_timeout, e.write, e.rdata, e.resp, e.tmo); end
            n_checks++; if ((at - acc) != int'(TMO) + 1) begin n_fail++; $display("FAIL tmo_latency: got %0d expected %0d", at - acc, TMO + 1); end
        end
        n_checks++; if ((ar_vcyc - s_ar) != int'(TMO)) begin n_fail++; $display("FAIL tmo_arvalid_cycles: got %0d expected %0d", ar_vcyc - s_ar, TMO); end
        n_checks++; if ({arvalid, rready} !== 2'b00) begin n_fail++; $display("FAIL tmo_valid_drop: got %b expected 00", {arvalid, rready}); end
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_cmd_ready: got %b expected 1", cmd_ready); end
        ar_lat = 0;
    endtask

    task automatic test_reset_mid_write();
        int acc, at, seen; bit ok, found; exp_t e;
        aw_lat = 1000; w_lat = 1000;
        send(1'b1, 32'h80, 32'h77, 4'hF, acc, ok);
        n_checks++; if (!ok || awvalid !== 1'b1) begin n_fail++; $display("FAIL rstw_awvalid_before: got %b expected 1", awvalid); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({awvalid, wvalid, cmd_ready} !== 3'b000) begin n_fail++; $display("FAIL rstw_async_clear: got %b expected 000", {awvalid, wvalid, cmd_ready}); end
        aw_lat = 0; w_lat = 0; cfg_bresp = 2'b11;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstw_cmd_ready: got %b expected 1", cmd_ready); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rstw_no_rsp: got %0d pulses expected 0", seen); end
        send(1'b1, 32'h84, 32'h99, 4'h1, acc, ok);
        if (ok) sb.push_back('{1'b1, 32'h0, 2'b11, 1'b0});
        wait_rsp(found, at);
        n_checks++; if (!(ok && found)) begin n_fail++; $display("FAIL rstw_recover: got accept=%0b rsp=%0b expected 1/1", ok, found); end
        if (found && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++; if ({rsp_write, rsp_resp, rsp_timeout} !== {e.write, e.resp, e.tmo}) begin n_fail++; $display("FAIL rstw_decerr: got %b/%b/%b expected %b/%b/%b", rsp_write, rsp_resp, rsp_timeout, e.write, e.resp, e.tmo); end
            n_checks++; if ((at - acc) != 4) begin n_fail++; $display("FAIL rstw_latency: got %0d expected 4", at - acc); end
        end
        cfg_bresp = 2'b00;
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_write_wready_first();
        test_back_to_back();
        test_timeout();
        test_reset_mid_write();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d pending expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
